keen_instruction_fetch: RTL and testbench

// - Consumer end of the program-counter stream: takes fetch addresses, issues in-order

---
 rtl/keen_pkg.sv | 15 +
 rtl/keen_fifo.sv | 60 ++++++
 rtl/keen_instruction_fetch.sv | 96 +++++++++
 tb/tb_keen_instruction_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keen_pkg.sv
// Shared constants and helpers for the keen instruction-fetch stage.
package keen_pkg;

   localparam int unsigned KEEN_FETCH_DEPTH = 2;

   function automatic int unsigned keen_ialign(input int unsigned ilen);
      return $clog2(ilen / 8);
   endfunction

   // Mask that clears the low ialign bits of an address.
   function automatic logic [63:0] keen_align_mask(input int unsigned ialign);
      return ~((64'd1 << ialign) - 64'd1);
   endfunction

endpackage

// File: rtl/keen_fifo.sv
// Power-of-two synchronous FIFO with synchronous clear and occupancy count.
module keen_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] Full = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != Full) || do_pop);

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr_q] <= push_data;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/keen_instruction_fetch.sv
// Instruction fetch: issues in-order imem requests with slot credits, buffers responses for
// decode, and drops in-flight responses after a flush.
module keen_instruction_fetch
   import keen_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ILEN   = 32,
   parameter int unsigned IALIGN = keen_ialign(ILEN),
   parameter int unsigned DEPTH  = KEEN_FETCH_DEPTH
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            fetch_pc_valid,
   output logic            fetch_pc_ready,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] AlignMask = XLEN'(keen_align_mask(IALIGN));
   localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

   logic [CW-1:0]        outstanding, buf_count, drop_q, drop_d;
   logic [XLEN-1:0]      req_addr, resp_addr;
   logic [XLEN+ILEN-1:0] buf_head;
   logic                 credit, accept, buf_push, buf_pop;

   // Each accepted request reserves a buffer slot, so a response always has room.
   assign credit = ({1'b0, outstanding} + {1'b0, buf_count}) < DepthW;

   assign req_addr       = fetch_pc & AlignMask;
   assign imem_req_valid = reset_n && fetch_pc_valid && credit && !flush;
   assign fetch_pc_ready = reset_n && imem_req_ready && credit && !flush;
   assign imem_req_addr  = reset_n ? req_addr : '0;
   assign accept         = fetch_pc_valid && fetch_pc_ready;

   assign buf_push   = imem_resp_valid && (drop_q == '0) && !flush;
   assign inst_valid = buf_count != '0;
   assign buf_pop    = inst_valid && inst_ready && !flush;
   assign inst_pc    = inst_valid ? buf_head[XLEN+ILEN-1:ILEN] : '0;
   assign inst       = inst_valid ? buf_head[ILEN-1:0] : '0;

   always_comb begin
      drop_d = drop_q;
      if (flush) begin
         // Everything still in flight after this cycle's response belongs to the old stream.
         drop_d = (imem_resp_valid && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
      end else if (imem_resp_valid && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) drop_q <= '0;
      else          drop_q <= drop_d;
   end

   // Address queue occupancy is the outstanding-request count.
   keen_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_addr_queue (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (1'b0),
      .push      (accept),
      .push_data (req_addr),
      .pop       (imem_resp_valid),
      .head      (resp_addr),
      .count     (outstanding)
   );

   keen_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_inst_buffer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (flush),
      .push      (buf_push),
      .push_data ({resp_addr, imem_resp_data}),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_keen_instruction_fetch.sv
// Self-checking bench for keen_instruction_fetch: directed scenarios plus random traffic against
// a queue-based model of the fetch stream and an in-order instruction memory.
module tb_keen_instruction_fetch;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n, flush, fetch_pc_valid, fetch_pc_ready, imem_req_valid, imem_req_ready;
   logic        imem_resp_valid, inst_valid, inst_ready;
   logic [31:0] fetch_pc, imem_req_addr, imem_resp_data, inst, inst_pc;

   always #5 clk = ~clk;

   keen_instruction_fetch #(
      .XLEN  (32),
      .ILEN  (32),
      .DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .fetch_pc        (fetch_pc),
      .fetch_pc_valid  (fetch_pc_valid),
      .fetch_pc_ready  (fetch_pc_ready),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   // A request in flight at the memory; live is cleared when a flush orphans it.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
      bit          live;
   } pend_t;

   pend_t       pend[$];
   logic [63:0] bq[$];
   logic [31:0] popped[$];
   int          cyc, last_due, lat_min, lat_max;
   int          vectors, miscompares;
   logic        obs_rdy, obs_rv, obs_iv;
   logic [31:0] obs_addr;
   int          acc_cnt, pop_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check combinational outputs against the model, advance the model.
   task automatic step(input bit pv, input logic [31:0] pc, input bit rr, input bit ir,
                       input bit fl);
      bit    rv, credit, exp_rdy, exp_rv, exp_iv, acc, pop;
      pend_t p;
      int    d;
      fetch_pc_valid = pv;
      fetch_pc       = pc;
      imem_req_ready = rr;
      inst_ready     = ir;
      flush          = fl;
      rv = 1'b0;
      if (pend.size() != 0) rv = (pend[0].due <= cyc);
      imem_resp_valid = rv;
      if (rv) imem_resp_data = pend[0].data;
      else    imem_resp_data = $urandom;
      #1;
      credit  = (pend.size() + bq.size()) < DEPTH;
      exp_rdy = rr && credit && !fl;
      exp_rv  = pv && credit && !fl;
      exp_iv  = bq.size() != 0;
      chk("fetch_pc_ready", fetch_pc_ready, exp_rdy);
      chk("imem_req_valid", imem_req_valid, exp_rv);
      chk("imem_req_addr", imem_req_addr, pc & 32'hffff_fffc);
      chk("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
         chk("inst_pc", inst_pc, bq[0][63:32]);
         chk("inst", inst, bq[0][31:0]);
      end
      obs_rdy  = fetch_pc_ready;
      obs_rv   = imem_req_valid;
      obs_addr = imem_req_addr;
      obs_iv   = inst_valid;
      if (pv && fetch_pc_ready) acc_cnt++;
      if (inst_valid && ir && !fl) begin
         popped.push_back(inst_pc);
         pop_cnt++;
      end
      acc = pv && exp_rdy;
      pop = exp_iv && ir && !fl;
      @(posedge clk);
      if (pop) void'(bq.pop_front());
      if (rv) begin
         p = pend.pop_front();
         if (p.live && !fl) bq.push_back({p.addr, p.data});
      end
      if (fl) begin
         bq.delete();
         foreach (pend[i]) pend[i].live = 1'b0;
      end
      if (acc) begin
         d = cyc + int'($urandom_range(lat_max, lat_min));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         p.addr   = pc & 32'hffff_fffc;
         p.data   = $urandom;
         p.due    = d;
         p.live   = 1'b1;
         pend.push_back(p);
      end
      cyc++;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (pend.size() + bq.size()) != 0; i++) step(0, 32'h0, 1, 1, 0);
      step(0, 32'h0, 1, 1, 0);
      chk("drain_inst_valid", obs_iv, 1'b0);
   endtask

   // Assert reset between edges and check every output falls to zero at once.
   task automatic reset_check();
      fetch_pc_valid  = 1'b1;
      fetch_pc        = 32'h8000_0010;
      imem_req_ready  = 1'b1;
      inst_ready      = 1'b1;
      flush           = 1'b0;
      imem_resp_valid = 1'b0;
      reset_n         = 1'b0;
      #1;
      chk("rst_fetch_pc_ready", fetch_pc_ready, 1'b0);
      chk("rst_imem_req_valid", imem_req_valid, 1'b0);
      chk("rst_imem_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      pend.delete();
      bq.delete();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      fetch_pc_valid = 1'b0;
      reset_n        = 1'b1;
      @(posedge clk);
      cyc++;
      last_due = cyc;
      #1;
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;
      fetch_pc_valid = 1'b0; fetch_pc = '0; imem_req_ready = 1'b0; inst_ready = 1'b0;
      flush = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      reset_n = 1'b1;
      #2;
      reset_check();

      // First request after reset.
      popped.delete();
      step(1, 32'h8000_0000, 1, 1, 0);
      chk("first_req_addr", obs_addr, 32'h8000_0000);
      chk("first_accept", obs_rdy, 1'b1);

      // Streaming with single-cycle memory: one instruction per cycle, in order.
      for (int i = 1; i <= 4; i++) step(1, 32'h8000_0000 + 32'(4 * i), 1, 1, 0);
      pop_cnt = 0;
      for (int i = 5; i <= 12; i++) step(1, 32'h8000_0000 + 32'(4 * i), 1, 1, 0);
      chk("stream_rate", 32'(pop_cnt), 32'd8);
      for (int i = 0; i < 3; i++) begin
         chk("stream_order", (popped.size() > i) ? popped[i] : 32'hdead_dead,
             32'h8000_0000 + 32'(4 * i));
      end
      drain();

      // Decode backpressure: DEPTH accepts, then one pop frees exactly one slot.
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) step(1, 32'h8000_0020 + 32'(4 * i), 1, 0, 0);
      chk("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
      chk("bp_ready_low", obs_rdy, 1'b0);
      acc_cnt = 0;
      step(1, 32'h8000_0080, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 32'h8000_0080, 1, 0, 0);
      chk("bp_one_more", 32'(acc_cnt), 32'd1);
      drain();

      // Flush with two requests outstanding: both responses discarded.
      lat_min = 4; lat_max = 4;
      step(1, 32'h8000_0040, 1, 1, 0);
      step(1, 32'h8000_0044, 1, 1, 0);
      step(1, 32'h8000_0048, 1, 1, 1);
      chk("flush_no_req", obs_rv, 1'b0);
      popped.delete();
      step(1, 32'h8000_0100, 1, 1, 0);
      drain();
      chk("flush2_pops", 32'(popped.size()), 32'd1);
      chk("flush2_first_pc", (popped.size() != 0) ? popped[0] : 32'hdead_dead, 32'h8000_0100);

      // Flush coincident with a response and a pop.
      lat_min = 2; lat_max = 2;
      step(1, 32'h8000_0200, 1, 0, 0);
      step(1, 32'h8000_0204, 1, 0, 0);
      step(1, 32'h8000_0208, 1, 0, 0);
      step(1, 32'h8000_020c, 1, 1, 1);
      popped.delete();
      step(1, 32'h8000_0300, 1, 1, 0);
      chk("flush_coincident_no_valid", obs_iv, 1'b0);
      drain();
      chk("flush_coincident_pops", 32'(popped.size()), 32'd1);
      chk("flush_coincident_pc", (popped.size() != 0) ? popped[0] : 32'hdead_dead,
          32'h8000_0300);

      // Misaligned fetch address.
      lat_min = 1; lat_max = 1;
      popped.delete();
      step(1, 32'h8000_0006, 1, 1, 0);
      chk("misaligned_req_addr", obs_addr, 32'h8000_0004);
      drain();
      chk("misaligned_inst_pc", (popped.size() != 0) ? popped[0] : 32'hdead_dead,
          32'h8000_0004);

      // Random traffic with variable memory latency and occasional flushes.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(3, 0) != 0), $urandom, bit'($urandom_range(3, 0) != 0),
              bit'($urandom_range(2, 0) != 0), bit'($urandom_range(15, 0) == 0));
      end

      // Reset in the middle of traffic, then resume.
      for (int i = 0; i < 3; i++) step(1, 32'h8000_0400 + 32'(4 * i), 1, 0, 0);
      reset_check();
      step(1, 32'h8000_0000, 1, 1, 0);
      chk("post_reset_req_addr", obs_addr, 32'h8000_0000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
